// File: rtl/alu_pkg.sv
// alu_pkg: command/response encodings and per-bank packet types shared by the ALU and its benches.
package alu_pkg;

    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_ADD = 2'd1,
        CMD_MUL = 2'd2,
        CMD_AND = 2'd3
    } command_names_t;

    typedef enum logic [1:0] {
        RSP_NONE     = 2'd0,
        RSP_SUCCESS  = 2'd1,
        RSP_OVERFLOW = 2'd2,
        RSP_ERROR    = 2'd3
    } response_names_t;

    typedef struct packed {
        command_names_t command;
        logic [31:0]    data1;
        logic [31:0]    data2;
    } input_packet_t;

    typedef struct packed {
        response_names_t response;
        logic [31:0]     data;
    } output_packet_t;

endpackage

// File: rtl/alu_bank.sv
// alu_bank: one independent ALU lane; captures a command, runs for EXEC_CYCLES edges,
// then pulses a response for one cycle while the result data is held until the next one.
module alu_bank
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  input_packet_t  in_i,
    output output_packet_t out_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESPOND} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    command_names_t cmd_q, cmd_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    output_packet_t out_q, out_d;
    output_packet_t res;
    logic [32:0]    sum;
    logic [63:0]    prod;

    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        prod = 64'(a_q) * 64'(b_q);
        res  = '{response: RSP_ERROR, data: 32'd0};
        case (cmd_q)
            CMD_ADD: res = '{response: sum[32] ? RSP_OVERFLOW : RSP_SUCCESS, data: sum[31:0]};
            CMD_MUL: res = '{response: |prod[63:32] ? RSP_OVERFLOW : RSP_SUCCESS, data: prod[31:0]};
            CMD_AND: res = '{response: RSP_SUCCESS, data: a_q & b_q};
            default: res = '{response: RSP_ERROR, data: 32'd0};
        endcase
    end

    // IDLE and RESPOND both accept a new command; a held command re-arms back-to-back.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        a_d            = a_q;
        b_d            = b_q;
        out_d.response = RSP_NONE;
        out_d.data     = out_q.data;
        if (state_q == S_EXEC) begin
            if (cnt_q == 4'd0) begin
                state_d = S_RESPOND;
                out_d   = res;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (in_i.command != CMD_NOP) begin
            state_d = S_EXEC;
            cnt_d   = 4'(EXEC_CYCLES);
            cmd_d   = in_i.command;
            a_d     = in_i.data1;
            b_d     = in_i.data2;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_NOP;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            out_q   <= '{response: RSP_NONE, data: 32'd0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/multi_bank_alu.sv
// multi_bank_alu: NUM_BANKS fully independent ALU banks sharing only clock and reset.
module multi_bank_alu
    import alu_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int EXEC_CYCLES = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  input_packet_t  input_packet  [NUM_BANKS],
    output output_packet_t output_packet [NUM_BANKS]
);

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        alu_bank #(.EXEC_CYCLES(EXEC_CYCLES)) u_bank (
            .clock (clock),
            .reset (reset),
            .in_i  (input_packet[i]),
            .out_o (output_packet[i])
        );
    end

endmodule

// File: tb/tb_multi_bank_alu.sv
// tb_multi_bank_alu: directed stimulus with a scoreboard of expected responses
// (bank, observation cycle, response, data) checked by a negedge monitor.
module tb_multi_bank_alu;
    import alu_pkg::*;

    localparam int NB   = 4;
    localparam int EXEC = 3;

    typedef struct {
        int              bank;
        int              cyc;
        response_names_t rsp;
        logic [31:0]     data;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset;
    input_packet_t  inp  [NB];
    output_packet_t outp [NB];
    exp_t           sbq  [$];
    int             cyc    = 0;
    int             checks = 0;
    int             errs   = 0;

    multi_bank_alu #(.NUM_BANKS(NB), .EXEC_CYCLES(EXEC)) dut (
        .clock         (clock),
        .reset         (reset),
        .input_packet  (inp),
        .output_packet (outp)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int b, input command_names_t c, input logic [31:0] d1,
                         input logic [31:0] d2, input response_names_t r, input logic [31:0] d);
        inp[b] = '{command: c, data1: d1, data2: d2};
        sbq.push_back('{bank: b, cyc: cyc + EXEC + 2, rsp: r, data: d});
    endtask

    task automatic release_bank(input int b);
        inp[b].command = CMD_NOP;
        inp[b].data1   = $urandom;
        inp[b].data2   = $urandom;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Any non-NONE response must match the oldest pending entry for that bank, in the exact cycle.
    always @(negedge clock) begin
        for (int b = 0; b < NB; b++) begin
            if (outp[b].response != RSP_NONE) begin
                int idx;
                idx = -1;
                for (int k = 0; k < sbq.size(); k++)
                    if (idx < 0 && sbq[k].bank == b) idx = k;
                chk($sformatf("bank%0d_expected_response", b), idx >= 0, 1);
                if (idx >= 0) begin
                    chk($sformatf("bank%0d_rsp", b), outp[b].response, sbq[idx].rsp);
                    chk($sformatf("bank%0d_data", b), outp[b].data, sbq[idx].data);
                    chk($sformatf("bank%0d_cycle", b), cyc, sbq[idx].cyc);
                    sbq.delete(idx);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int b = 0; b < NB; b++) inp[b] = '{command: CMD_NOP, data1: 32'd0, data2: 32'd0};
        step(3);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("reset_rsp%0d", b), outp[b].response, RSP_NONE);
            chk($sformatf("reset_data%0d", b), outp[b].data, 32'd0);
        end
        // Commands are presented together with reset release: first edge must accept them.
        reset = 1'b0;
        issue(0, CMD_ADD, 32'h0000_0005, 32'h0000_0007, RSP_SUCCESS, 32'h0000_000C);
        issue(1, CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0002, RSP_OVERFLOW, 32'h0000_0001);
        step(1);
        release_bank(0);
        release_bank(1);
        step(6);
        chk("hold_rsp0", outp[0].response, RSP_NONE);
        chk("hold_data0", outp[0].data, 32'h0000_000C);
        chk("hold_data1", outp[1].data, 32'h0000_0001);
        issue(3, CMD_MUL, 32'h0001_0000, 32'h0001_0000, RSP_OVERFLOW, 32'h0000_0000);
        step(1);
        release_bank(3);
        step(6);
        issue(3, CMD_MUL, 32'h0000_FFFF, 32'h0001_0001, RSP_SUCCESS, 32'hFFFF_FFFF);
        step(1);
        release_bank(3);
        step(6);
        for (int b = 0; b < NB; b++) begin
            issue(b, CMD_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, RSP_SUCCESS, 32'h3030_3030);
            step(1);
            release_bank(b);
        end
        step(8);
        for (int k = 0; k < 3; k++)
            sbq.push_back('{bank: 0, cyc: cyc + EXEC + 2 + k * (EXEC + 2), rsp: RSP_SUCCESS, data: 32'd2});
        inp[0] = '{command: CMD_ADD, data1: 32'd1, data2: 32'd1};
        step(2 * (EXEC + 2) + 1);
        release_bank(0);
        step(10);
        inp[2] = '{command: CMD_ADD, data1: 32'd9, data2: 32'd9};
        step(1);
        release_bank(2);
        step(1);
        reset = 1'b1;
        #1;
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("midop_reset_rsp%0d", b), outp[b].response, RSP_NONE);
            chk($sformatf("midop_reset_data%0d", b), outp[b].data, 32'd0);
        end
        step(1);
        reset = 1'b0;
        issue(2, CMD_ADD, 32'd3, 32'd4, RSP_SUCCESS, 32'd7);
        step(1);
        release_bank(2);
        step(10);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
